scratchpad_lsu: RTL and testbench

Load/store unit that issues warp-wide memory instructions to the per-lane scratchpad. It accepts one vector load or store per handshake and computes a per-lane address as base plus offset. It masks inactive and out-of-range lanes, drives the scratchpad write and read ports for exactly one execute cycle, and returns load data or store completion on a response handshake. It sits between the shader issue stage and the scratchpad memory, acting as the initiator for the scratchpad's per-lane ports.

---
 rtl/GPU_Shader_pkg.sv | 6 +
 rtl/scratchpad_lsu.sv | 136 +++++++++++++
 tb/tb_scratchpad_lsu.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/GPU_Shader_pkg.sv
// GPU_Shader_pkg: shared shader geometry and word type for the scratchpad datapath
package GPU_Shader_pkg;
    localparam int lanes = 4;
    localparam int MEM_DEPTH = 256;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/scratchpad_lsu.sv
// scratchpad_lsu: issues one warp-wide load/store to the per-lane scratchpad and returns a response
module scratchpad_lsu
    import GPU_Shader_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [lanes-1:0]      req_mask,
    input  word_t                 req_base,
    input  word_t                 req_offset    [lanes],
    input  word_t                 req_data      [lanes],
    input  logic [3:0]            req_tag,
    output logic [lanes-1:0]      sp_write_en,
    output logic [ADDR_WIDTH-1:0] sp_write_addr [lanes],
    output word_t                 sp_write_data [lanes],
    output logic [ADDR_WIDTH-1:0] sp_read_addr  [lanes],
    input  word_t                 sp_read_data  [lanes],
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_is_store,
    output logic [lanes-1:0]      resp_mask,
    output logic [lanes-1:0]      resp_fault,
    output word_t                 resp_data     [lanes],
    output logic [3:0]            resp_tag
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [lanes-1:0] mask_q, mask_d;
    word_t            base_q, base_d;
    word_t            offset_q [lanes];
    word_t            offset_d [lanes];
    word_t            data_q [lanes];
    word_t            data_d [lanes];
    logic [3:0]       tag_q, tag_d;
    logic [lanes-1:0] resp_mask_q, resp_mask_d;
    logic [lanes-1:0] resp_fault_q, resp_fault_d;
    word_t            resp_data_q [lanes];
    word_t            resp_data_d [lanes];
    word_t            full [lanes];
    logic [lanes-1:0] fault, ok;

    // Full address wraps at word width; range check uses the unwrapped-to-ADDR_WIDTH value
    always_comb begin
        for (int i = 0; i < lanes; i++) begin
            full[i]  = base_q + offset_q[i];
            fault[i] = mask_q[i] & (full[i] >= word_t'(MEM_DEPTH));
            ok[i]    = mask_q[i] & ~fault[i];
        end
    end

    always_comb begin
        for (int i = 0; i < lanes; i++) begin
            sp_write_addr[i] = full[i][ADDR_WIDTH-1:0];
            sp_read_addr[i]  = full[i][ADDR_WIDTH-1:0];
            sp_write_data[i] = data_q[i];
            resp_data[i]     = resp_data_q[i];
        end
    end

    assign req_ready     = rst_n && (state_q == IDLE);
    assign sp_write_en   = (state_q == EXEC && is_store_q) ? ok : '0;
    assign resp_valid    = (state_q == RESP);
    assign resp_is_store = is_store_q;
    assign resp_mask     = resp_mask_q;
    assign resp_fault    = resp_fault_q;
    assign resp_tag      = tag_q;

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        mask_d       = mask_q;
        base_d       = base_q;
        offset_d     = offset_q;
        data_d       = data_q;
        tag_d        = tag_q;
        resp_mask_d  = resp_mask_q;
        resp_fault_d = resp_fault_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    is_store_d = req_is_store;
                    mask_d     = req_mask;
                    base_d     = req_base;
                    offset_d   = req_offset;
                    data_d     = req_data;
                    tag_d      = req_tag;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                resp_mask_d  = ok;
                resp_fault_d = fault;
                for (int i = 0; i < lanes; i++)
                    resp_data_d[i] = (ok[i] && !is_store_q) ? sp_read_data[i] : '0;
                state_d = RESP;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            mask_q       <= '0;
            base_q       <= '0;
            tag_q        <= '0;
            resp_mask_q  <= '0;
            resp_fault_q <= '0;
            for (int i = 0; i < lanes; i++) begin
                offset_q[i]    <= '0;
                data_q[i]      <= '0;
                resp_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            mask_q       <= mask_d;
            base_q       <= base_d;
            tag_q        <= tag_d;
            resp_mask_q  <= resp_mask_d;
            resp_fault_q <= resp_fault_d;
            offset_q     <= offset_d;
            data_q       <= data_d;
            resp_data_q  <= resp_data_d;
        end
    end
endmodule

// File: tb/tb_scratchpad_lsu.sv
// tb_scratchpad_lsu: directed plus randomized checks of scratchpad_lsu against an address/memory reference model
module tb_scratchpad_lsu;
    import GPU_Shader_pkg::*;

    logic       clk = 0, rst_n = 0, req_valid = 0, req_is_store = 0, resp_ready = 0;
    logic [3:0] req_mask = 0, req_tag = 0;
    word_t      req_base = 0;
    word_t      req_offset [4];
    word_t      req_data [4];
    word_t      sp_read_data [4];
    word_t      sp_write_data [4];
    word_t      resp_data [4];
    logic [7:0] sp_write_addr [4];
    logic [7:0] sp_read_addr [4];
    logic [3:0] sp_write_en, resp_mask, resp_fault, resp_tag;
    logic       req_ready, resp_valid, resp_is_store;

    word_t      mem [256];
    word_t      ref_mem [256];

    logic       t_store;
    logic [3:0] t_mask, t_tag;
    word_t      t_base;
    word_t      t_off [4];
    word_t      t_data [4];

    logic       exp_store;
    logic [3:0] exp_ok, exp_fault, exp_tag;
    logic [7:0] exp_addr [4];
    word_t      exp_data [4];

    int n_pass = 0, n_total = 0;

    scratchpad_lsu dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_mask(req_mask), .req_base(req_base),
        .req_offset(req_offset), .req_data(req_data), .req_tag(req_tag),
        .sp_write_en(sp_write_en), .sp_write_addr(sp_write_addr), .sp_write_data(sp_write_data),
        .sp_read_addr(sp_read_addr), .sp_read_data(sp_read_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_store(resp_is_store),
        .resp_mask(resp_mask), .resp_fault(resp_fault), .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    // Scratchpad: combinational read, lanes written in index order so the highest lane wins
    always_comb for (int i = 0; i < 4; i++) sp_read_data[i] = mem[sp_read_addr[i]];
    always @(posedge clk)
        for (int i = 0; i < 4; i++) if (sp_write_en[i]) mem[sp_write_addr[i]] <= sp_write_data[i];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        req_valid = 1; req_is_store = t_store; req_mask = t_mask; req_base = t_base; req_tag = t_tag;
        for (int i = 0; i < 4; i++) begin
            req_offset[i] = t_off[i];
            req_data[i]   = t_data[i];
        end
    endtask

    task automatic wait_accept(output int waited);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic model_exec();
        longint unsigned a;
        exp_store = t_store; exp_tag = t_tag; exp_ok = '0; exp_fault = '0;
        for (int i = 0; i < 4; i++) begin
            a = ({32'b0, t_base} + {32'b0, t_off[i]}) % 64'h1_0000_0000;
            exp_addr[i] = a[7:0];
            if (t_mask[i]) begin
                if (a >= 256) exp_fault[i] = 1'b1;
                else exp_ok[i] = 1'b1;
            end
            exp_data[i] = (!t_store && exp_ok[i]) ? ref_mem[exp_addr[i]] : '0;
        end
        if (t_store)
            for (int i = 0; i < 4; i++) if (exp_ok[i]) ref_mem[exp_addr[i]] = t_data[i];
        chk("exec_wr_en", sp_write_en, t_store ? exp_ok : 4'b0);
        chk("exec_req_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("exec_rd_addr", sp_read_addr[i], exp_addr[i]);
            if (t_store && exp_ok[i]) chk("exec_wr_data", sp_write_data[i], t_data[i]);
        end
    endtask

    task automatic check_resp();
        @(posedge clk); #1;
        chk("resp_valid", resp_valid, 1);
        chk("resp_req_ready", req_ready, 0);
        chk("resp_wr_en", sp_write_en, 0);
        chk("resp_tag", resp_tag, exp_tag);
        chk("resp_is_store", resp_is_store, exp_store);
        chk("resp_mask", resp_mask, exp_ok);
        chk("resp_fault", resp_fault, exp_fault);
        for (int i = 0; i < 4; i++) chk("resp_data", resp_data[i], exp_data[i]);
    endtask

    task automatic handshake();
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        chk("hs_resp_valid", resp_valid, 0);
        chk("hs_req_ready", req_ready, 1);
    endtask

    task automatic transact();
        int w;
        drive_req();
        wait_accept(w);
        model_exec();
        check_resp();
        handshake();
    endtask

    task automatic set_req(input logic st, input logic [3:0] m, input word_t b, input logic [3:0] tg);
        t_store = st; t_mask = m; t_base = b; t_tag = tg;
    endtask

    initial begin
        int w;
        word_t held;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            req_offset[i] = '0; req_data[i] = '0; t_off[i] = '0; t_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_wr_en", sp_write_en, 0);
        chk("rst_resp_tag", resp_tag, 0);
        chk("rst_resp_mask", resp_mask, 0);
        chk("rst_resp_data", resp_data[0], 0);

        // Reset asserted mid-EXEC of a store must abort the write
        set_req(1, 4'hF, 100, 4'h9);
        for (int i = 0; i < 4; i++) begin
            t_off[i] = i; t_data[i] = 32'hDEAD_0000 + i;
        end
        drive_req();
        wait_accept(w);
        chk("rstx_wr_en_before", sp_write_en, 4'hF);
        rst_n = 0;
        #1;
        chk("rstx_wr_en_after", sp_write_en, 0);
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        chk("rstx_req_ready", req_ready, 1);
        chk("rstx_resp_valid", resp_valid, 0);
        for (int i = 0; i < 4; i++) chk("rstx_mem", mem[100 + i], ref_mem[100 + i]);

        // Store then load of the same four words
        set_req(1, 4'hF, 16, 4'h3);
        for (int i = 0; i < 4; i++) begin
            t_off[i] = i; t_data[i] = 32'hA + i;
        end
        transact();
        set_req(0, 4'hF, 16, 4'h4);
        transact();
        chk("sl_lane0", resp_data[0], 32'hA);
        chk("sl_lane3", resp_data[3], 32'hD);

        // Fault and mask
        set_req(0, 4'b1011, 250, 4'h5);
        t_off[0] = 0; t_off[1] = 5; t_off[2] = 6; t_off[3] = 10;
        transact();
        chk("flt_fault", resp_fault, 4'b1000);
        chk("flt_mask", resp_mask, 4'b0011);

        // Wrap past the top of the word range
        set_req(0, 4'b0001, 32'hFFFF_FFFF, 4'h6);
        for (int i = 0; i < 4; i++) t_off[i] = 2;
        transact();
        chk("wrap_fault", resp_fault, 0);
        chk("wrap_data", resp_data[0], ref_mem[1]);

        // All-zero mask
        set_req(1, 4'b0000, 3, 4'h7);
        transact();

        // Duplicate store addresses: highest lane wins
        set_req(1, 4'hF, 7, 4'h8);
        for (int i = 0; i < 4; i++) begin
            t_off[i] = 0; t_data[i] = i + 1;
        end
        transact();
        set_req(0, 4'b0001, 7, 4'h8);
        transact();
        chk("dup_lane0", resp_data[0], 4);

        // Backpressure with a pending request
        set_req(0, 4'hF, 16, 4'h5);
        for (int i = 0; i < 4; i++) t_off[i] = i;
        drive_req();
        wait_accept(w);
        model_exec();
        check_resp();
        held = resp_data[0];
        set_req(1, 4'hF, 40, 4'h6);
        for (int i = 0; i < 4; i++) begin
            t_off[i] = i; t_data[i] = $urandom;
        end
        drive_req();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_resp_data", resp_data[0], held);
            chk("bp_resp_tag", resp_tag, 4'h5);
        end
        handshake();
        wait_accept(w);
        chk("bp_accept_latency", w, 0);
        model_exec();
        check_resp();
        handshake();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            set_req($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 : $urandom_range(150, 255), 4'($urandom));
            for (int i = 0; i < 4; i++) begin
                t_off[i] = $urandom_range(0, 40); t_data[i] = $urandom;
            end
            transact();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
